// File: rtl/nes_alu_pkg.sv
// Shared constants for the NES 6502-compatible ALU: operation codes, status flag
// bit positions and flag-operation sub-codes.
package nes_alu_pkg;

    localparam logic [3:0] OP_ORA  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_EOR  = 4'b0010;
    localparam logic [3:0] OP_ADC  = 4'b0011;
    localparam logic [3:0] OP_PSA  = 4'b0100;
    localparam logic [3:0] OP_PSB  = 4'b0101;
    localparam logic [3:0] OP_CMP  = 4'b0110;
    localparam logic [3:0] OP_SBC  = 4'b0111;
    localparam logic [3:0] OP_ASL  = 4'b1000;
    localparam logic [3:0] OP_ROL  = 4'b1001;
    localparam logic [3:0] OP_LSR  = 4'b1010;
    localparam logic [3:0] OP_ROR  = 4'b1011;
    localparam logic [3:0] OP_FLAG = 4'b1100;
    localparam logic [3:0] OP_BIT  = 4'b1101;
    localparam logic [3:0] OP_DEC  = 4'b1110;
    localparam logic [3:0] OP_INC  = 4'b1111;

    localparam int unsigned FLAG_N = 7;
    localparam int unsigned FLAG_V = 6;
    localparam int unsigned FLAG_D = 3;
    localparam int unsigned FLAG_I = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 0;

    localparam logic [2:0] OPC_CLC = 3'b000;
    localparam logic [2:0] OPC_SEC = 3'b001;
    localparam logic [2:0] OPC_CLI = 3'b010;
    localparam logic [2:0] OPC_SEI = 3'b011;
    localparam logic [2:0] OPC_CLV = 3'b101;
    localparam logic [2:0] OPC_CLD = 3'b110;
    localparam logic [2:0] OPC_SED = 3'b111;

    // Replace N and Z of a status byte according to a result.
    function automatic logic [7:0] set_nz(input logic [7:0] p, input logic [7:0] r);
        logic [7:0] q;
        q = p;
        q[FLAG_N] = r[7];
        q[FLAG_Z] = (r == 8'h00);
        return q;
    endfunction

endpackage

// File: rtl/nes_alu_adder.sv
// 8-bit adder with carry-in; provides sum, carry-out and signed overflow.
module nes_alu_adder (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout,
    output logic       o_ovf
);

    logic [8:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {8'h00, i_cin};
    assign o_sum  = w_full[7:0];
    assign o_cout = w_full[8];
    // Overflow: operands share a sign that the result does not.
    assign o_ovf  = (i_a[7] == i_b[7]) && (o_sum[7] != i_a[7]);

endmodule

// File: rtl/nes_alu.sv
// NES 6502 ALU (binary mode): combinational result/status plus registered copies.
module nes_alu
    import nes_alu_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] OP,
    input  logic [7:0] P_IN,
    input  logic [2:0] OPC,
    output logic [7:0] AR,
    output logic [7:0] AF,
    output logic [7:0] AR_Q,
    output logic [7:0] AF_Q
);

    logic [7:0] w_add_a;
    logic [7:0] w_add_b;
    logic       w_add_cin;
    logic [7:0] w_sum;
    logic       w_cout;
    logic       w_ovf;
    logic [7:0] w_ar;
    logic [7:0] w_af;
    logic       w_nz;
    logic       w_c;
    logic [7:0] r_ar;
    logic [7:0] r_af;

    assign w_c = P_IN[FLAG_C];

    // One adder serves ADC, SBC, CMP, INC and DEC by steering its operands.
    always_comb begin
        w_add_a   = A;
        w_add_b   = B;
        w_add_cin = w_c;
        case (OP)
            OP_SBC: w_add_b = ~B;
            OP_CMP: begin
                w_add_b   = ~B;
                w_add_cin = 1'b1;
            end
            OP_INC: begin
                w_add_a   = B;
                w_add_b   = 8'h00;
                w_add_cin = 1'b1;
            end
            OP_DEC: begin
                w_add_a   = B;
                w_add_b   = 8'hFF;
                w_add_cin = 1'b0;
            end
            default: ;
        endcase
    end

    nes_alu_adder u_adder (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_cin (w_add_cin),
        .o_sum (w_sum),
        .o_cout(w_cout),
        .o_ovf (w_ovf)
    );

    always_comb begin
        w_ar = B;
        w_af = P_IN;
        w_nz = 1'b0;
        case (OP)
            OP_ORA: begin w_ar = A | B; w_nz = 1'b1; end
            OP_AND: begin w_ar = A & B; w_nz = 1'b1; end
            OP_EOR: begin w_ar = A ^ B; w_nz = 1'b1; end
            OP_ADC, OP_SBC: begin
                w_ar         = w_sum;
                w_af[FLAG_C] = w_cout;
                w_af[FLAG_V] = w_ovf;
                w_nz         = 1'b1;
            end
            OP_CMP: begin
                w_ar         = w_sum;
                w_af[FLAG_C] = w_cout;
                w_nz         = 1'b1;
            end
            OP_PSA: w_ar = A;
            OP_PSB: begin w_ar = B; w_nz = 1'b1; end
            OP_ASL: begin w_ar = {B[6:0], 1'b0}; w_af[FLAG_C] = B[7]; w_nz = 1'b1; end
            OP_ROL: begin w_ar = {B[6:0], w_c};  w_af[FLAG_C] = B[7]; w_nz = 1'b1; end
            OP_LSR: begin w_ar = {1'b0, B[7:1]}; w_af[FLAG_C] = B[0]; w_nz = 1'b1; end
            OP_ROR: begin w_ar = {w_c, B[7:1]};  w_af[FLAG_C] = B[0]; w_nz = 1'b1; end
            OP_FLAG: begin
                w_ar = B;
                case (OPC)
                    OPC_CLC: w_af[FLAG_C] = 1'b0;
                    OPC_SEC: w_af[FLAG_C] = 1'b1;
                    OPC_CLI: w_af[FLAG_I] = 1'b0;
                    OPC_SEI: w_af[FLAG_I] = 1'b1;
                    OPC_CLV: w_af[FLAG_V] = 1'b0;
                    OPC_CLD: w_af[FLAG_D] = 1'b0;
                    OPC_SED: w_af[FLAG_D] = 1'b1;
                    default: ;
                endcase
            end
            OP_BIT: begin
                w_ar         = A;
                w_af[FLAG_N] = B[7];
                w_af[FLAG_V] = B[6];
                w_af[FLAG_Z] = ((A & B) == 8'h00);
            end
            OP_DEC, OP_INC: begin w_ar = w_sum; w_nz = 1'b1; end
            default: ;
        endcase
        if (w_nz) begin
            w_af = set_nz(w_af, w_ar);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ar <= 8'h00;
            r_af <= 8'h00;
        end else begin
            r_ar <= w_ar;
            r_af <= w_af;
        end
    end

    assign AR   = w_ar;
    assign AF   = w_af;
    assign AR_Q = r_ar;
    assign AF_Q = r_af;

endmodule

// File: tb/tb_nes_alu.sv
// Self-checking bench for nes_alu: directed vectors plus random stimulus against a
// behavioural model built from integer arithmetic.
module tb_nes_alu;

    logic       CLK;
    logic       RST;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] OP;
    logic [7:0] P_IN;
    logic [2:0] OPC;
    logic [7:0] AR;
    logic [7:0] AF;
    logic [7:0] AR_Q;
    logic [7:0] AF_Q;

    int n_checks = 0;
    int n_pass   = 0;

    nes_alu dut (
        .CLK (CLK),
        .RST (RST),
        .A   (A),
        .B   (B),
        .OP  (OP),
        .P_IN(P_IN),
        .OPC (OPC),
        .AR  (AR),
        .AF  (AF),
        .AR_Q(AR_Q),
        .AF_Q(AF_Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Reference model: arithmetic on integers, flags derived from numeric ranges.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [7:0] p, input logic [2:0] opc,
                         output logic [7:0] ar, output logic [7:0] af);
        int ua, ub, sa, sb, c, s, sv;
        bit nz;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c  = int'(p[0]);
        af = p;
        ar = b;
        nz = 1'b1;
        case (op)
            4'd0: ar = a | b;
            4'd1: ar = a & b;
            4'd2: ar = a ^ b;
            4'd3: begin
                s  = ua + ub + c;
                sv = sa + sb + c;
                ar = 8'(s);
                af[0] = (s > 255);
                af[6] = (sv > 127) || (sv < -128);
            end
            4'd7: begin
                s  = ua - ub - (1 - c);
                sv = sa - sb - (1 - c);
                ar = 8'(s);
                af[0] = (s >= 0);
                af[6] = (sv > 127) || (sv < -128);
            end
            4'd6: begin
                ar = 8'(ua - ub);
                af[0] = (ua >= ub);
            end
            4'd4: begin ar = a; nz = 1'b0; end
            4'd5: ar = b;
            4'd8: begin ar = 8'((ub * 2) % 256); af[0] = (ub >= 128); end
            4'd9: begin ar = 8'((ub * 2 + c) % 256); af[0] = (ub >= 128); end
            4'd10: begin ar = 8'(ub / 2); af[0] = (ub % 2 == 1); end
            4'd11: begin ar = 8'(ub / 2 + c * 128); af[0] = (ub % 2 == 1); end
            4'd12: begin
                nz = 1'b0;
                case (opc)
                    3'd0: af[0] = 1'b0;
                    3'd1: af[0] = 1'b1;
                    3'd2: af[2] = 1'b0;
                    3'd3: af[2] = 1'b1;
                    3'd5: af[6] = 1'b0;
                    3'd6: af[3] = 1'b0;
                    3'd7: af[3] = 1'b1;
                    default: ;
                endcase
            end
            4'd13: begin
                ar = a;
                nz = 1'b0;
                af[7] = (ub >= 128);
                af[6] = ((ub / 64) % 2 == 1);
                af[1] = ((a & b) == 8'h00);
            end
            4'd14: ar = 8'((ub + 255) % 256);
            default: ar = 8'((ub + 1) % 256);
        endcase
        if (nz) begin
            af[7] = (int'(ar) >= 128);
            af[1] = (ar == 8'h00);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [7:0] p, input logic [2:0] opc);
        @(negedge CLK);
        A = a; B = b; OP = op; P_IN = p; OPC = opc;
        #1;
    endtask

    task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] op, input logic [7:0] p,
                            input logic [2:0] opc, input logic [7:0] exp_ar,
                            input logic [7:0] exp_af);
        drive(a, b, op, p, opc);
        check_eq({tag, "_ar"}, AR, exp_ar);
        check_eq({tag, "_af"}, AF, exp_af);
    endtask

    logic [7:0] m_ar, m_af, q_ar, q_af;
    logic       rst_v;

    initial begin
        RST = 1'b1;
        A = 8'h50; B = 8'h50; OP = 4'b0011; P_IN = 8'h00; OPC = 3'b000;
        @(posedge CLK);
        #1;
        check_eq("rst_ar_q", AR_Q, 8'h00);
        check_eq("rst_af_q", AF_Q, 8'h00);
        check_eq("rst_comb_ar", AR, 8'hA0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("cap_ar_q", AR_Q, 8'hA0);
        check_eq("cap_af_q", AF_Q, 8'hC0);

        directed("adc", 8'h50, 8'h50, 4'b0011, 8'h00, 3'b000, 8'hA0, 8'hC0);
        directed("sbc", 8'h00, 8'h01, 4'b0111, 8'h01, 3'b000, 8'hFF, 8'h80);
        directed("cmp", 8'h40, 8'h40, 4'b0110, 8'h00, 3'b000, 8'h00, 8'h03);
        directed("ror", 8'h00, 8'h01, 4'b1011, 8'h01, 3'b000, 8'h80, 8'h81);
        directed("lsr", 8'h00, 8'h01, 4'b1010, 8'h80, 3'b000, 8'h00, 8'h03);
        directed("sed", 8'h00, 8'h33, 4'b1100, 8'h00, 3'b111, 8'h33, 8'h08);
        directed("clv", 8'h00, 8'h33, 4'b1100, 8'hC0, 3'b101, 8'h33, 8'h80);
        directed("sei", 8'h00, 8'h33, 4'b1100, 8'h00, 3'b011, 8'h33, 8'h04);
        directed("fnop", 8'h00, 8'h33, 4'b1100, 8'hFF, 3'b100, 8'h33, 8'hFF);
        directed("bit", 8'h0F, 8'hC0, 4'b1101, 8'h00, 3'b000, 8'h0F, 8'hC2);
        directed("dec", 8'h00, 8'h00, 4'b1110, 8'h00, 3'b000, 8'hFF, 8'h80);
        directed("inc", 8'h00, 8'hFF, 4'b1111, 8'h00, 3'b000, 8'h00, 8'h02);
        directed("sta", 8'h00, 8'h12, 4'b0100, 8'h3A, 3'b000, 8'h00, 8'h3A);

        // Random: combinational result each cycle, registered copy one edge later.
        for (int i = 0; i < 400; i++) begin
            rst_v = ($urandom_range(0, 15) == 0);
            drive(8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), 3'($urandom));
            RST = rst_v;
            #1;
            model(A, B, OP, P_IN, OPC, m_ar, m_af);
            check_eq("rnd_ar", AR, m_ar);
            check_eq("rnd_af", AF, m_af);
            q_ar = rst_v ? 8'h00 : m_ar;
            q_af = rst_v ? 8'h00 : m_af;
            @(posedge CLK);
            #1;
            check_eq("rnd_ar_q", AR_Q, q_ar);
            check_eq("rnd_af_q", AF_Q, q_af);
            RST = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nes_alu.md
Name: nes_alu

Overview:
- Arithmetic/logic unit of the NES 6502-compatible CPU core (binary only, no decimal mode).
- Combinational datapath: operands A/B, 4-bit operation code, current status P and opcode[7:5] in; result AR and next status AF out, valid in the same cycle.
- CPU sequencer decides whether AR/AF are written back.
- Registered copies AR_Q/AF_Q are provided for debug and pipelining.

Parameters:
- none (data width fixed at 8).

Ports:
- CLK    in   1  system clock; all flops on its rising edge
- RST    in   1  synchronous reset, active-high
- A      in   8  operand A (A/X/Y, selected by CPU)
- B      in   8  operand B (DIN/A/X/Y/S, selected by CPU)
- OP     in   4  operation select
- P_IN   in   8  current status: 7 N, 6 V, 5 unused, 4 B, 3 D, 2 I, 1 Z, 0 C
- OPC    in   3  opcode[7:5]; sub-selects flag operations
- AR     out  8  combinational result
- AF     out  8  combinational next status
- AR_Q   out  8  AR registered one cycle
- AF_Q   out  8  AF registered one cycle

Behaviour:
- AF = P_IN with only the listed flags replaced. Bits 5 and 4 always pass through.
- "NZ" means: N = AR[7], Z = (AR == 0).
- OP 0000 ORA: AR = A|B; flags NZ.
- OP 0001 AND: AR = A&B; flags NZ.
- OP 0010 EOR: AR = A^B; flags NZ.
- OP 0011 ADC: sum = A + B + C (9-bit); AR = sum[7:0]; C = sum[8]; V = (A[7]==B[7]) && (AR[7]!=A[7]); flags NZ.
- OP 0111 SBC: identical to ADC with B replaced by ~B. C=1 means no borrow.
- OP 0110 CMP: AR = A - B (8-bit); C = (A >= B) unsigned; flags NZ; V unchanged.
- OP 0100 pass-A (store): AR = A; AF = P_IN.
- OP 0101 pass-B (load/transfer/pull): AR = B; flags NZ.
- OP 1000 ASL: AR = {B[6:0],0}; C = B[7]; flags NZ.
- OP 1001 ROL: AR = {B[6:0],C}; C = B[7]; flags NZ.
- OP 1010 LSR: AR = {0,B[7:1]}; C = B[0]; flags NZ (N = 0).
- OP 1011 ROR: AR = {C,B[7:1]}; C = B[0]; flags NZ.
- OP 1100 flag ops, AR = B, selected by OPC:
  - 000 C=0; 001 C=1
  - 010 I=0; 011 I=1
  - 101 V=0
  - 110 D=0; 111 D=1
  - 100: AF = P_IN
- OP 1101 BIT: AR = A; N = B[7]; V = B[6]; Z = ((A&B) == 0).
- OP 1110 DEC: AR = B - 1, wraps 0x00->0xFF; flags NZ.
- OP 1111 INC: AR = B + 1, wraps 0xFF->0x00; flags NZ.
- Carry-in C is always P_IN[0].
- No X/Z propagation for any OP value: every case fully assigned, with AR = B and AF = P_IN as the default.
- Registered outputs:
  - Every rising CLK: AR_Q <= AR, AF_Q <= AF.
  - RST=1 at an edge: AR_Q = 0x00, AF_Q = 0x00, taking priority over capture.
  - Combinational AR/AF are unaffected by RST.
  - Reset mid-sequence only clears the registers; the first edge after RST falls captures normally.
- Latency: AR/AF 0 cycles; AR_Q/AF_Q 1 cycle.

Decomposition:
- Shared package nes_alu_pkg holds:
  - OP code constants (OP_ORA..OP_INC)
  - flag bit indices (FLAG_N=7, FLAG_V=6, FLAG_D=3, FLAG_I=2, FLAG_Z=1, FLAG_C=0)
  - OPC codes for the flag operations
- One sub-module, nes_alu_adder: 8-bit add with carry-in, producing sum, carry-out and overflow. Shared by ADC, SBC (inverted B), CMP (inverted B, carry-in 1), INC and DEC.

Test Plan:
- ADC: A=0x50, B=0x50, P_IN=0x00, OP=0011 -> AR=0xA0, AF=0xC0 (N,V set).
- SBC: A=0x00, B=0x01, P_IN=0x01, OP=0111 -> AR=0xFF, AF=0x80 (borrow, C=0). CMP: A=0x40, B=0x40, P_IN=0x00, OP=0110 -> AR=0x00, AF=0x03.
- ROR: B=0x01, P_IN=0x01, OP=1011 -> AR=0x80, AF=0x81. LSR: B=0x01, P_IN=0x80 -> AR=0x00, AF=0x03.
- Flag ops, OP=1100:
  - OPC=111, P_IN=0x00 -> AF=0x08
  - OPC=101, P_IN=0xC0 -> AF=0x80
  - OPC=011, P_IN=0x00 -> AF=0x04
- BIT: A=0x0F, B=0xC0, P_IN=0x00, OP=1101 -> AF=0xC2, AR=0x0F. DEC: B=0x00, OP=1110 -> AR=0xFF, AF=0x80. INC: B=0xFF, OP=1111 -> AR=0x00, AF=0x02.
- Registers:
  - With ADC vector applied, RST=1 for one edge -> AR_Q=0x00, AF_Q=0x00.
  - Next edge with RST=0 -> AR_Q=0xA0, AF_Q=0xC0.
